// File: rtl/block_serial_subtractor.sv
// Block-serial unsigned subtractor: computes a - b - bin one SIZE-bit block per cycle using carry-select adders.
// Optional macro BSS_OVERFLOW_EN adds a signed-overflow output (ovf).
module block_serial_subtractor #(
  parameter int N    = 32,
  parameter int SIZE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic [1:0]   state_dbg,
`ifdef BSS_OVERFLOW_EN
  output logic         ovf,
`endif
  output logic         busy
);

  localparam int BLOCK = (SIZE >= 1) ? N / SIZE : 1;
  localparam int CW    = (BLOCK > 1) ? $clog2(BLOCK) : 1;

  if (SIZE < 1) begin : g_bad_size
    $error("block_serial_subtractor: SIZE must be at least 1");
  end else if (N % SIZE != 0) begin : g_bad_width
    $error("block_serial_subtractor: N must be a multiple of SIZE");
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // in_ready is high only in IDLE, out_valid only in DONE, and DONE holds
  // diff/bout until out_ready is seen.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, b_q, diff_q;
  logic            carry_q;
  logic [CW-1:0]   cnt_q;
  logic            last_blk;
  int              idx;
  logic [SIZE-1:0] a_blk, nb_blk;
  logic [SIZE:0]   sum0, sum1, sel;

  assign last_blk = (cnt_q == CW'(BLOCK - 1));
  assign idx      = int'(cnt_q) * SIZE;
  assign a_blk    = a_q[idx +: SIZE];
  assign nb_blk   = ~b_q[idx +: SIZE];
  // Both carry-in outcomes are formed in parallel; the registered carry picks one.
  assign sum0     = {1'b0, a_blk} + {1'b0, nb_blk};
  assign sum1     = sum0 + {{SIZE{1'b0}}, 1'b1};
  assign sel      = carry_q ? sum1 : sum0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = RUN;
      end
      RUN:  if (last_blk) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef BSS_OVERFLOW_EN
  logic ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef BSS_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= b;
          carry_q <= ~bin;
          cnt_q   <= '0;
        end
        RUN: begin
          diff_q[idx +: SIZE] <= sel[SIZE-1:0];
          carry_q             <= sel[SIZE];
          if (last_blk) begin
`ifdef BSS_OVERFLOW_EN
            // Carry into the MSB is recovered from the MSB sum bit and its operands.
            ovf_q <= (a_blk[SIZE-1] ^ nb_blk[SIZE-1] ^ sel[SIZE-1]) ^ sel[SIZE];
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign diff      = diff_q;
  assign bout      = out_valid & ~carry_q;
  assign state_dbg = state_q;
`ifdef BSS_OVERFLOW_EN
  assign ovf       = out_valid & ovf_q;
`endif

endmodule

// File: tb/tb_block_serial_subtractor.sv
// Randomized self-checking bench for block_serial_subtractor against an arithmetic reference model.
// Checks ovf as well when BSS_OVERFLOW_EN is defined.
module tb_block_serial_subtractor;
  localparam int N     = 32;
  localparam int SIZE  = 4;
  localparam int BLOCK = N / SIZE;
  localparam int W     = N + 2;

  logic         clk, rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0] a, b, diff;
  logic         bin, bout, busy;
  logic [1:0]   state_dbg;
  logic         ovf_obs;
`ifdef BSS_OVERFLOW_EN
  logic         ovf;
  assign ovf_obs = ovf;
`else
  assign ovf_obs = 1'b0;
`endif

  block_serial_subtractor #(.N(N), .SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .state_dbg(state_dbg),
`ifdef BSS_OVERFLOW_EN
    .ovf(ovf),
`endif
    .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference: {ovf, bout, diff} from plain integer arithmetic
  function automatic logic [W-1:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb, input logic mbin);
    longint ua, ub, sa, sb, r, lim;
    logic [N-1:0] d;
    logic bo, ov;
    ua  = longint'({32'd0, ma});
    ub  = longint'({32'd0, mb});
    d   = N'(ua - ub - longint'(mbin));
    bo  = (ua < ub + longint'(mbin));
    sa  = longint'($signed(ma));
    sb  = longint'($signed(mb));
    r   = sa - sb - longint'(mbin);
    lim = longint'(1) << (N - 1);
    ov  = (r < -lim) || (r > lim - 1);
    return {ov, bo, d};
  endfunction

  // driver: one full operation with `stall` cycles of backpressure in DONE
  task automatic run_op(input logic [N-1:0] op_a, input logic [N-1:0] op_b, input logic op_bin, input int stall);
    logic [W-1:0] e;
    logic [N-1:0] hold_d;
    logic         hold_b;
    int lat;
    check("in_ready_idle", in_ready, 1);
    a = op_a; b = op_b; bin = op_bin; in_valid = 1'b1;
    exp_q.push_back(model(op_a, op_b, op_bin));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
    check("busy_run", busy, 1);
    lat = 0;
    while (!out_valid && lat < 4 * BLOCK) begin
      @(posedge clk); #1;
      lat++;
      if (lat < BLOCK) a = $urandom;
    end
    check("latency", 64'(lat), 64'(BLOCK));
    if (!out_valid) return;
    e = exp_q.pop_front();
    check("diff", diff, e[N-1:0]);
    check("bout", bout, e[N]);
`ifdef BSS_OVERFLOW_EN
    check("ovf", ovf_obs, e[N+1]);
`endif
    hold_d = diff; hold_b = bout;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom;
      @(posedge clk); #1;
      check("stall_valid", out_valid, 1);
      check("stall_ready", in_ready, 0);
      check("stall_diff", diff, hold_d);
      check("stall_bout", bout, hold_b);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("exit_valid", out_valid, 0);
    check("exit_ready", in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    check("rst_ovf", ovf_obs, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed cases
    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 0);
    run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 0);
    run_op(32'h0000_0100, 32'h0000_0001, 1'b0, 0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 0);
    run_op(32'h0000_0010, 32'h0000_000F, 1'b1, 5);
    run_op(32'h0000_0001, 32'h0000_0002, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);

    // reset during RUN block 3 aborts the operation
    a = 32'h1234_5678; b = 32'h0000_0001; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_diff", diff, 0);
    check("abort_bout", bout, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", in_ready, 1);
    begin
      int seen = 0;
      for (int i = 0; i < 2 * BLOCK; i++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      check("abort_no_result", 64'(seen), 0);
    end

    // randomized operations
    for (int i = 0; i < 24; i++) begin
      logic [N-1:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra + N'($urandom_range(0, 2)) : N'($urandom);
      run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    check("queue_empty", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_serial_subtractor.md
BLOCK_SERIAL_SUBTRACTOR -- requirements
Module: block_serial_subtractor

Interface
REQ-001 Parameter N, default 32, operand/result width in bits.
REQ-002 Parameter SIZE, default 4, block width in bits; BLOCK = N/SIZE blocks are processed, one per cycle.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operands a, b, bin valid.
REQ-006 in_ready  output  1  block accepts operands.
REQ-007 a  input  N  minuend, unsigned.
REQ-008 b  input  N  subtrahend, unsigned.
REQ-009 bin  input  1  borrow in.
REQ-010 out_valid  output  1  diff/bout valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 diff  output  N  (a - b - bin) mod 2^N.
REQ-013 bout  output  1  borrow out; 1 when a < b + bin (unsigned).
REQ-014 busy  output  1  high in RUN or DONE.

Function
REQ-015 FSM states IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 IDLE: on in_valid && in_ready at an edge, register a, b, carry = ~bin; clear block counter; go to RUN.
REQ-017 RUN: each cycle processes block k (bits SIZE*k+SIZE-1 : SIZE*k), LSB block first. It forms a + ~b for that slice with carry-in 0 and with carry-in 1 in parallel and selects by the registered carry. It writes the selected slice into the diff register and updates the carry with the selected block carry-out.
REQ-018 RUN: when counter = BLOCK-1, go to DONE after that block is written; otherwise increment the counter.
REQ-019 Latency: input handshake at edge t gives out_valid = 1 from edge t+BLOCK (8 cycles at defaults).
REQ-020 DONE: bout = ~carry; diff and bout are held stable while out_valid && !out_ready.
REQ-021 DONE: on out_ready, go to IDLE at that edge; out_valid drops the next cycle.
REQ-022 in_valid is ignored outside IDLE; input changes during RUN/DONE have no effect on the result.
REQ-023 BLOCK = 1 is legal: exactly one RUN cycle.
REQ-024 N not a multiple of SIZE, or SIZE < 1, SHALL cause an elaboration error.
REQ-025 The borrow chain wraps to zero between operations: each new accept reloads carry from bin, with no residue from the prior result.

Reset
REQ-026 rst_n low immediately forces IDLE, counter 0, and operand, diff and carry registers 0.
REQ-027 Output values during reset: in_ready = 1, out_valid = 0, busy = 0, diff = 0, bout = 0 (ovf = 0 if present).
REQ-028 Reset asserted mid-RUN or in DONE aborts the operation; no result is produced for it.

Configuration
REQ-029 Macro BSS_OVERFLOW_EN defined: adds output port ovf (1 bit). In DONE, ovf = 1 when the two's-complement value a - b - bin lies outside [-2^(N-1), 2^(N-1)-1], equal to the carry into the MSB XOR the carry out of the MSB. ovf is registered with the last block and held with diff.
REQ-030 Macro BSS_OVERFLOW_EN undefined: no ovf port and no overflow logic; all other behaviour is identical.

Verification (N=32, SIZE=4)
REQ-031 a=0x00000005, b=0x00000003, bin=0 -> diff=0x00000002, bout=0, out_valid exactly 8 cycles after the handshake.
REQ-032 a=0x00000000, b=0x00000001, bin=0 -> diff=0xFFFFFFFF, bout=1; then a=0x00000100, b=0x00000001 -> diff=0x000000FF, bout=0 (borrow crosses blocks).
REQ-033 a=0x80000000, b=0x00000001, bin=0 -> diff=0x7FFFFFFF, bout=0, ovf=1 with BSS_OVERFLOW_EN; a=0x00000010, b=0x0000000F, bin=1 -> diff=0, bout=0, ovf=0.
REQ-034 Backpressure: out_ready=0 for 5 cycles in DONE -> diff, bout and out_valid stable, in_ready=0, and a new in_valid is ignored; out_ready=1 -> in_ready=1 the next cycle.
REQ-035 Back-to-back: second operation a=1, b=2, bin=0 accepted the cycle after DONE exit -> diff=0xFFFFFFFF, bout=1, with no dependence on the prior carry.
REQ-036 rst_n pulsed low during RUN block 3 -> outputs take reset values asynchronously; after release in_ready=1, and no out_valid appears for the aborted operation.
